verifier_chi_dot_product: RTL

//  Downstream consumer of the verifier's chi-vector stage: computes sum_i chi[i]*v[i] mod F_Q.
//  v is a vector of claimed input-layer values. The output is the verifier's multilinear-extension evaluation V~(tau).

---
 rtl/verifier_chi_pkg.sv | 29 ++
 rtl/verifier_chi_mac_lane.sv | 21 ++
 rtl/verifier_chi_dot_product.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/verifier_chi_pkg.sv
// Shared field types, FSM state encoding and mod-F_Q helpers for the verifier chi stages.
// F_NBITS / F_Q default to the Mersenne prime 2^61-1 when not supplied by the build.
`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFFFFFFFFFFFFFF
`endif

package verifier_chi_pkg;
    localparam int FE_W = `F_NBITS;
    typedef logic [FE_W-1:0] fe_t;
    localparam fe_t FE_Q = `F_Q;

    typedef enum logic [1:0] {IDLE, MAC, RED, FIN} chi_state_e;

    function automatic fe_t fe_add(input fe_t a, input fe_t b);
        logic [FE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, FE_Q}) s = s - {1'b0, FE_Q};
        return fe_t'(s);
    endfunction

    function automatic fe_t fe_mul(input fe_t a, input fe_t b);
        logic [2*FE_W-1:0] p;
        p = {{FE_W{1'b0}}, a} * {{FE_W{1'b0}}, b};
        return fe_t'(p % {{FE_W{1'b0}}, FE_Q});
    endfunction
endpackage

// File: rtl/verifier_chi_mac_lane.sv
// One multiply-accumulate lane over F_Q: acc <= clr ? 0 : en ? acc + a*b : acc.
module verifier_chi_mac_lane
    import verifier_chi_pkg::*;
(
    input  logic            clk,
    input  logic            rstb,
    input  logic            clr,
    input  logic            en,
    input  logic [FE_W-1:0] a,
    input  logic [FE_W-1:0] b,
    output logic [FE_W-1:0] acc
);
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= fe_add(acc, fe_mul(a, b));
    end
endmodule

// File: rtl/verifier_chi_dot_product.sv
// Dot product sum chi[i]*v[i] mod F_Q with nParallel MAC lanes and a serial lane reduction.
// Optional macro VERIFIER_CHI_DOT_EARLY_EN enables the short (early) vector mode.
module verifier_chi_dot_product
    import verifier_chi_pkg::*;
#(
    parameter int nValBits   = 4,
    parameter int nEarlyBits = 3,
    parameter int nParallel  = 2
)(
    input  logic                             clk,
    input  logic                             rstb,
    input  logic                             en,
    input  logic                             early,
    input  logic [(1<<nValBits)*FE_W-1:0]    chi_in,
    input  logic [(1<<nValBits)*FE_W-1:0]    vals_in,
    output logic [FE_W-1:0]                  result,
    output logic                             ready
);
    localparam int NVALUES = 1 << nValBits;
    localparam int STEP_W  = nValBits + 1;
    localparam logic [STEP_W-1:0] FULL_STEPS = STEP_W'(NVALUES / nParallel);
    localparam logic [STEP_W-1:0] LAST_LANE  = STEP_W'(nParallel - 1);

    chi_state_e        state, state_nx;
    logic [STEP_W-1:0] step, n_steps;
    fe_t               chi_r [NVALUES];
    fe_t               val_r [NVALUES];
    fe_t               acc   [nParallel];
    fe_t               red_operand;
    logic              lane_clr, lane_en, red_en, accept;

    assign ready  = (state == IDLE);
    assign accept = ready & en;

`ifdef VERIFIER_CHI_DOT_EARLY_EN
    localparam logic [STEP_W-1:0] EARLY_STEPS = STEP_W'((1 << nEarlyBits) / nParallel);

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb)
            n_steps <= '0;
        else if (accept)
            n_steps <= early ? EARLY_STEPS : FULL_STEPS;
    end
`else
    logic unused_early;
    assign unused_early = early | (nEarlyBits > nValBits);
    assign n_steps      = FULL_STEPS;
`endif

    // Operand vectors are plain data: captured on accept, never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NVALUES; i++) begin
                chi_r[i] <= chi_in[i*FE_W +: FE_W];
                val_r[i] <= vals_in[i*FE_W +: FE_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        lane_clr = 1'b0;
        lane_en  = 1'b0;
        red_en   = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nx = MAC;
                    lane_clr = 1'b1;
                end
            end
            MAC: begin
                lane_en = 1'b1;
                if (step == n_steps - STEP_W'(1))
                    state_nx = (nParallel == 1) ? FIN : RED;
            end
            RED: begin
                red_en = 1'b1;
                if (step == LAST_LANE)
                    state_nx = FIN;
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // step indexes vector chunks during MAC, then the lane being folded into lane 0 during RED.
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb)
            step <= '0;
        else begin
            case (state)
                MAC:     step <= (step == n_steps - STEP_W'(1)) ? STEP_W'(1) : step + STEP_W'(1);
                RED:     step <= step + STEP_W'(1);
                default: step <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb)
            result <= '0;
        else if (state == FIN)
            result <= acc[0];
    end

    always_comb begin
        red_operand = '0;
        for (int k = 1; k < nParallel; k++)
            if (step == STEP_W'(k))
                red_operand = acc[k];
    end

    for (genvar p = 0; p < nParallel; p++) begin : g_lane
        logic [nValBits-1:0] idx;
        fe_t                 lane_a, lane_b;
        logic                lane_go;

        assign idx = nValBits'(step * nParallel + p);

        // Lane 0 doubles as the reduction adder: acc[0] += acc[k] * 1.
        if (p == 0) begin : g_red
            assign lane_a  = red_en ? red_operand : chi_r[idx];
            assign lane_b  = red_en ? fe_t'(1) : val_r[idx];
            assign lane_go = lane_en | red_en;
        end else begin : g_mac
            assign lane_a  = chi_r[idx];
            assign lane_b  = val_r[idx];
            assign lane_go = lane_en;
        end

        verifier_chi_mac_lane u_lane (
            .clk  (clk),
            .rstb (rstb),
            .clr  (lane_clr),
            .en   (lane_go),
            .a    (lane_a),
            .b    (lane_b),
            .acc  (acc[p])
        );
    end
endmodule
